// File: rtl/multicycle_control.sv
// multicycle_control -- main control FSM of a multicycle MIPS datapath.
//
// One instruction runs over several cycles on a shared ALU and a unified
// memory. The memory states stall on mem_ready. Two conditions enter a sticky
// FAULT state that only rst clears: a memory access that stalls past
// STALL_LIMIT cycles, and an opcode that is not recognised in DECODE.
//
// Build option: define JUMP_EN to decode opcode 000010 (j) into the JUMP
// state. Without it, j is an illegal opcode and pc_source never equals 10.
//
// Parameters
//   STALL_LIMIT  consecutive mem_ready=0 cycles allowed in one memory state
//                (0 disables the timeout)
//   CNT_W        stall counter width, 2**CNT_W > STALL_LIMIT
//
// Ports
//   clk, rst       clock (rising edge), synchronous active-high reset
//   instr_op       IR[31:26], looked at only in DECODE
//   mem_ready      memory finishes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load when the ALU zero flag is set (beq)
//   iord           memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read request, held until mem_ready
//   mem_write      memory write request, held until mem_ready
//   ir_write       IR load
//   mem_to_reg     write-back source: 1 = MDR, 0 = ALUOut
//   reg_dst        destination register: 1 = rd, 0 = rt
//   reg_write      register file write
//   alu_src_a      ALU A: 0 = PC, 1 = register A
//   alu_src_b      ALU B: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
//   alu_op         00 = add, 01 = sub, 10 = decode funct
//   pc_source      00 = ALU result, 01 = ALUOut, 10 = jump target
//   state_o        current state code
//   fault          sticky trap indicator
module multicycle_control #(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr_op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state_o,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC    = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
`ifdef JUMP_EN
    S_JUMP    = 4'd11,
`endif
    S_FAULT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  // lw and sw share MEM_ADR; the opcode is only valid in DECODE, so the
  // load/store choice is captured there for use one cycle later.
  logic             is_sw, is_sw_nx;
  logic             mem_state, timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt   <= '0;
      is_sw <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      is_sw <= is_sw_nx;
    end
  end

  assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // mem_ready wins over the timeout in the same cycle.
  assign timeout   = mem_state && !mem_ready && (STALL_LIMIT != 0) && (cnt == LIMIT);

  always_comb begin
    state_nx = state;
    is_sw_nx = is_sw;
    case (state)
      S_FETCH:   if (mem_ready) state_nx = S_DECODE;
                 else if (timeout) state_nx = S_FAULT;
      S_DECODE: begin
        is_sw_nx = (instr_op == OP_SW);
        case (instr_op)
          OP_RTYPE:     state_nx = S_EXEC;
          OP_LW, OP_SW: state_nx = S_MEM_ADR;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_ADDI:      state_nx = S_ADDI_EX;
`ifdef JUMP_EN
          OP_J:         state_nx = S_JUMP;
`endif
          default:      state_nx = S_FAULT;
        endcase
      end
      S_MEM_ADR: state_nx = is_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready) state_nx = S_MEM_WB;
                 else if (timeout) state_nx = S_FAULT;
      S_MEM_WB:  state_nx = S_FETCH;
      S_MEM_WR:  if (mem_ready) state_nx = S_FETCH;
                 else if (timeout) state_nx = S_FAULT;
      S_EXEC:    state_nx = S_ALU_WB;
      S_ALU_WB:  state_nx = S_FETCH;
      S_BRANCH:  state_nx = S_FETCH;
      S_ADDI_EX: state_nx = S_ADDI_WB;
      S_ADDI_WB: state_nx = S_FETCH;
`ifdef JUMP_EN
      S_JUMP:    state_nx = S_FETCH;
`endif
      S_FAULT:   state_nx = S_FAULT;
      default:   state_nx = S_FAULT;
    endcase
  end

  // Any state change clears the counter, which covers entry into each memory
  // state; within a memory state it counts stall cycles and saturates.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state)
      cnt_nx = '0;
    else if (mem_state && !mem_ready && cnt != LIMIT)
      cnt_nx = cnt + CNT_W'(1);
  end

  // Moore outputs; only FETCH looks at mem_ready (IR/PC load on completion).
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    fault         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEM_ADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEM_RD:  begin mem_read = 1'b1; iord = 1'b1; end
      S_MEM_WB:  begin mem_to_reg = 1'b1; reg_write = 1'b1; end
      S_MEM_WR:  begin mem_write = 1'b1; iord = 1'b1; end
      S_EXEC:    begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_ALU_WB:  begin reg_dst = 1'b1; reg_write = 1'b1; end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_ADDI_EX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_ADDI_WB: reg_write = 1'b1;
`ifdef JUMP_EN
      S_JUMP:    begin pc_write = 1'b1; pc_source = 2'b10; end
`endif
      S_FAULT:   fault = 1'b1;
      default:   ;
    endcase
    // Reset takes effect at the next edge; suppress every strobe meanwhile so
    // an interrupted instruction cannot write anything.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      fault         = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  localparam int LIM = 15;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       fault;
  } ctrl_t;

  logic       clk = 1'b1;
  logic       rst, mem_ready;
  logic [5:0] instr_op;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;
  logic       fault;

  multicycle_control #(.STALL_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_o(state_o), .fault(fault)
  );

  always #5 clk = ~clk;

  int    total = 0, bad = 0, ncyc = 0;
  int    q_st[$];
  ctrl_t q_c[$];

  // Expected control word of each state, straight from the state table.
  function automatic ctrl_t ex(input int st, input logic rdy);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_dst = 1; c.reg_write = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      10: c.reg_write = 1;
      11: begin c.pc_write = 1; c.pc_source = 2'b10; end
      15: c.fault = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  // One clock cycle of stimulus plus its expected response (st<0: state unknown).
  task automatic cyc(input logic r, input logic rdy, input logic [5:0] op,
                     input int st, input ctrl_t c);
    rst = r; mem_ready = rdy; instr_op = op;
    q_st.push_back(st);
    q_c.push_back(c);
    @(posedge clk); #1;
  endtask

  // Issue one instruction as a list of states, inserting the requested stall
  // cycles in memory states. Reports whether the FSM ended up in FAULT.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm,
                           output bit faulted);
    int   ph[$];
    int   s;
    logic rdy;
    faulted = 0;
    ph = {0, 1};
    case (op)
      6'b000000: ph = {ph, 6, 7};
      6'b100011: ph = {ph, 2, 3, 4};
      6'b101011: ph = {ph, 2, 5};
      6'b000100: ph = {ph, 8};
      6'b001000: ph = {ph, 9, 10};
`ifdef JUMP_EN
      6'b000010: ph = {ph, 11};
`endif
      default:   ph = {ph, 15};
    endcase
    foreach (ph[k]) begin
      if (ph[k] inside {0, 3, 5}) begin
        s = (ph[k] == 0) ? sf : sm;
        for (int i = 0; i < s; i++) begin
          cyc(0, 0, r6(), ph[k], ex(ph[k], 0));
          if (i == LIM) begin faulted = 1; return; end
        end
        cyc(0, 1, r6(), ph[k], ex(ph[k], 1));
      end else begin
        rdy = 1'($urandom);
        cyc(0, rdy, (ph[k] == 1) ? op : r6(), ph[k], ex(ph[k], rdy));
        if (ph[k] == 15) begin faulted = 1; return; end
      end
    end
  endtask

  // Hold in FAULT for a few cycles, then reset back to FETCH.
  task automatic fault_then_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1'($urandom), r6(), 15, ex(15, 0));
    cyc(1, 1'($urandom), r6(), 15, '0);
  endtask

  // Monitor: compares every cycle that has an expectation queued.
  int    m_st;
  ctrl_t m_c, m_got;
  always @(negedge clk) begin
    ncyc++;
    if (q_st.size() > 0) begin
      m_st = q_st.pop_front();
      m_c  = q_c.pop_front();
      m_got = '{pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, fault};
      if (m_st >= 0) begin
        total++;
        if (state_o !== 4'(m_st)) begin
          bad++;
          $display("FAIL state cyc=%0d got=%0d want=%0d", ncyc, state_o, m_st);
        end
      end
      total++;
      if (m_got !== m_c) begin
        bad++;
        $display("FAIL ctrl cyc=%0d state=%0d got=%h want=%h", ncyc, state_o, m_got, m_c);
      end
    end
  end

  logic [5:0] legal[5];
  bit f;

  initial begin
    legal[0] = 6'b000000; legal[1] = 6'b100011; legal[2] = 6'b101011;
    legal[3] = 6'b000100; legal[4] = 6'b001000;
    rst = 1; mem_ready = 1; instr_op = '0;
    #1;
    // reset: two cycles, all strobes low
    cyc(1, 1, r6(), -1, '0);
    cyc(1, 1, r6(), 0, '0);
    // directed: lw, sw with 3 stalls in MEM_WR, beq, R-type, addi
    run_instr(6'b100011, 0, 0, f);
    run_instr(6'b101011, 0, 3, f);
    run_instr(6'b000100, 0, 0, f);
    run_instr(6'b000000, 2, 0, f);
    run_instr(6'b001000, 1, 0, f);
    // random legal instructions with random stalls
    for (int n = 0; n < 40; n++) begin
      run_instr(legal[$urandom_range(0, 4)], $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(4, LIM) : $urandom_range(0, 3), f);
    end
    // fetch timeout: 16 stalls -> FAULT, sticky, reset
    run_instr(6'b001000, LIM + 1, 0, f);
    if (f) fault_then_reset();
    // 15 stalls then ready: no fault
    run_instr(6'b001000, LIM, 0, f);
    // MEM_RD timeout
    run_instr(6'b100011, 0, LIM + 1, f);
    if (f) fault_then_reset();
    // reset aborts an in-flight lw in MEM_ADR
    cyc(0, 1, r6(), 0, ex(0, 1));
    cyc(0, 1, 6'b100011, 1, ex(1, 1));
    cyc(1, 1, r6(), 2, '0);
    // j: JUMP or FAULT depending on build
    run_instr(6'b000010, 0, 0, f);
    if (f) fault_then_reset();
    // opcode 111111 always faults; reset recovers
    run_instr(6'b111111, 0, 0, f);
    if (f) fault_then_reset();
    run_instr(6'b100011, 0, 1, f);
    // the queue must be fully drained by the monitor
    @(negedge clk); #1;
    total++;
    if (q_st.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q_st.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
